// File: rtl/exc_ctrl_pkg.sv
// Shared constants and types for the MEM-stage exception controller.
package exc_ctrl_pkg;

    // Default general exception entry point
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    // Exception codes reported to CP0 (0 means no exception)
    localparam logic [4:0] EXC_CODE_NONE = 5'd0;
    localparam logic [4:0] EXC_CODE_INT  = 5'd1;
    localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CODE_ADES = 5'd5;
    localparam logic [4:0] EXC_CODE_SYS  = 5'd8;
    localparam logic [4:0] EXC_CODE_BP   = 5'd9;
    localparam logic [4:0] EXC_CODE_RI   = 5'd10;
    localparam logic [4:0] EXC_CODE_OV   = 5'd12;
    localparam logic [4:0] EXC_CODE_ERET = 5'd14;

    // CP0 register indices used for write-back forwarding
    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    // Bit positions inside the MEM-stage exception flag vector
    localparam int unsigned EXC_BIT_ADEL_IF = 0;
    localparam int unsigned EXC_BIT_RI      = 1;
    localparam int unsigned EXC_BIT_OV      = 2;
    localparam int unsigned EXC_BIT_SYS     = 3;
    localparam int unsigned EXC_BIT_BP      = 4;
    localparam int unsigned EXC_BIT_ERET    = 5;
    localparam int unsigned EXC_BIT_ADEL_LD = 6;
    localparam int unsigned EXC_BIT_ADES    = 7;

    // Which address is reported as BadVAddr for the selected exception
    typedef enum logic [1:0] {
        BAD_NONE = 2'd0,
        BAD_PC   = 2'd1,
        BAD_DATA = 2'd2
    } bad_sel_e;

    // Controller states: normal commit, or holding a redirect for fetch
    typedef enum logic {
        ST_IDLE       = 1'b0,
        ST_WAIT_FETCH = 1'b1
    } state_e;

endpackage

// File: rtl/exc_ctrl_prio.sv
// Fixed-priority encoder: exception flags plus pending interrupt to code and BadVAddr source.
module exc_prio
    import exc_ctrl_pkg::*;
(
    input  logic [7:0] exc_flags_i,
    input  logic       int_pending_i,
    output logic [4:0] exc_code_o,
    output bad_sel_e   bad_sel_o
);

    // Interrupt wins over everything; then flags in the architectural order
    always_comb begin
        exc_code_o = EXC_CODE_NONE;
        bad_sel_o  = BAD_NONE;
        if (int_pending_i) begin
            exc_code_o = EXC_CODE_INT;
        end else if (exc_flags_i[EXC_BIT_ADEL_IF]) begin
            exc_code_o = EXC_CODE_ADEL;
            bad_sel_o  = BAD_PC;
        end else if (exc_flags_i[EXC_BIT_RI]) begin
            exc_code_o = EXC_CODE_RI;
        end else if (exc_flags_i[EXC_BIT_OV]) begin
            exc_code_o = EXC_CODE_OV;
        end else if (exc_flags_i[EXC_BIT_SYS]) begin
            exc_code_o = EXC_CODE_SYS;
        end else if (exc_flags_i[EXC_BIT_BP]) begin
            exc_code_o = EXC_CODE_BP;
        end else if (exc_flags_i[EXC_BIT_ERET]) begin
            exc_code_o = EXC_CODE_ERET;
        end else if (exc_flags_i[EXC_BIT_ADEL_LD]) begin
            exc_code_o = EXC_CODE_ADEL;
            bad_sel_o  = BAD_DATA;
        end else if (exc_flags_i[EXC_BIT_ADES]) begin
            exc_code_o = EXC_CODE_ADES;
            bad_sel_o  = BAD_DATA;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// MEM/commit-stage exception controller: forwarding, selection, flush and fetch redirect.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [7:0]  mem_exc_i,
    input  logic [31:0] mem_badaddr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    input  logic        redirect_ready_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] exc_count_o
);

    state_e      state_q, state_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] exc_count_q, exc_count_d;

    logic [31:0] status_eff;
    logic [31:0] cause_eff;
    logic [31:0] epc_eff;
    logic        int_pending;
    logic        commit;
    logic        take;
    logic [4:0]  prio_code;
    bad_sel_e    prio_bad_sel;
    logic        unused_bits;

    // Forward an in-flight mtc0 so a just-written Status/Cause/EPC is seen this cycle
    always_comb begin
        status_eff = cp0_status_i;
        cause_eff  = cp0_cause_i;
        epc_eff    = cp0_epc_i;
        if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_REG_STATUS)) begin
            status_eff = wb_cp0_data_i;
        end
        if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_REG_CAUSE)) begin
            cause_eff[9:8] = wb_cp0_data_i[9:8];
        end
        if (wb_cp0_we_i && (wb_cp0_waddr_i == CP0_REG_EPC)) begin
            epc_eff = wb_cp0_data_i;
        end
    end

    assign int_pending = (|(cause_eff[15:8] & status_eff[15:8])) & status_eff[0] & ~status_eff[1];
    assign commit      = ~rst & (state_q == ST_IDLE) & mem_valid_i & ~stall_i;
    assign take        = commit & (prio_code != EXC_CODE_NONE);

    // Only interrupt-mask, IE and EXL matter for interrupt pending
    assign unused_bits = ^{status_eff[31:16], status_eff[7:2], cause_eff[31:16], cause_eff[7:0]};

    exc_prio u_prio (
        .exc_flags_i   (mem_exc_i),
        .int_pending_i (int_pending),
        .exc_code_o    (prio_code),
        .bad_sel_o     (prio_bad_sel)
    );

    // Same-cycle report to CP0 and pipeline squash; silent outside a commit cycle
    always_comb begin
        excepttype_o = 32'd0;
        bad_addr_o   = 32'd0;
        if (take) begin
            excepttype_o = {27'd0, prio_code};
            case (prio_bad_sel)
                BAD_PC:   bad_addr_o = mem_pc_i;
                BAD_DATA: bad_addr_o = mem_badaddr_i;
                default:  bad_addr_o = 32'd0;
            endcase
        end
        flush_o = ~rst & (take | (state_q == ST_WAIT_FETCH));
    end

    assign current_inst_addr_o = mem_pc_i;
    assign is_in_delayslot_o   = mem_in_delayslot_i;
    assign redirect_valid_o    = (state_q == ST_WAIT_FETCH);
    assign redirect_pc_o       = redirect_pc_q;
    assign exc_count_o         = exc_count_q;

    // Take an exception into WAIT_FETCH, then release once fetch accepts the redirect
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        exc_count_d   = exc_count_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d       = ST_WAIT_FETCH;
                    redirect_pc_d = (prio_code == EXC_CODE_ERET) ? epc_eff : EXC_VECTOR;
                    exc_count_d   = exc_count_q + 32'd1;
                end
            end
            ST_WAIT_FETCH: begin
                if (redirect_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, redirect target and exception counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            redirect_pc_q <= 32'd0;
            exc_count_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            exc_count_q   <= exc_count_d;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [7:0]  mem_exc_i;
    logic [31:0] mem_badaddr_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic        redirect_ready_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] exc_count_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: is a redirect outstanding, its target, and exceptions taken
    bit          model_wait;
    logic [31:0] model_pc;
    logic [31:0] model_count;

    exc_ctrl #(.EXC_VECTOR(VEC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_i             (stall_i),
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_exc_i           (mem_exc_i),
        .mem_badaddr_i       (mem_badaddr_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .wb_cp0_we_i         (wb_cp0_we_i),
        .wb_cp0_waddr_i      (wb_cp0_waddr_i),
        .wb_cp0_data_i       (wb_cp0_data_i),
        .redirect_ready_i    (redirect_ready_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .redirect_valid_o    (redirect_valid_o),
        .redirect_pc_o       (redirect_pc_o),
        .exc_count_o         (exc_count_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------

    function automatic logic [31:0] ref_status();
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) return wb_cp0_data_i;
        return cp0_status_i;
    endfunction

    function automatic logic [31:0] ref_cause();
        logic [31:0] c;
        c = cp0_cause_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) c[9:8] = wb_cp0_data_i[9:8];
        return c;
    endfunction

    function automatic logic [31:0] ref_epc();
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) return wb_cp0_data_i;
        return cp0_epc_i;
    endfunction

    function automatic bit ref_int();
        logic [31:0] s;
        logic [31:0] c;
        bit any;
        s = ref_status();
        c = ref_cause();
        any = 1'b0;
        for (int i = 0; i < 8; i++) if (s[8+i] && c[8+i]) any = 1'b1;
        return any && s[0] && !s[1];
    endfunction

    function automatic bit ref_commit();
        return !rst && !model_wait && mem_valid_i && !stall_i;
    endfunction

    // Flag bits are listed in priority order, so the lowest set bit wins
    function automatic int ref_code();
        int codes [8] = '{4, 10, 12, 8, 9, 14, 4, 5};
        if (!ref_commit()) return 0;
        if (ref_int()) return 1;
        for (int i = 0; i < 8; i++) if (mem_exc_i[i]) return codes[i];
        return 0;
    endfunction

    function automatic logic [31:0] ref_bad();
        if (!ref_commit() || ref_int()) return 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (mem_exc_i[i]) begin
                if (i == 0) return mem_pc_i;
                if (i == 6 || i == 7) return mem_badaddr_i;
                return 32'd0;
            end
        end
        return 32'd0;
    endfunction

    function automatic bit ref_flush();
        return !rst && ((ref_code() != 0) || model_wait);
    endfunction

    // Advance the model across one rising edge using the inputs currently applied
    task automatic clock_edge();
        bit          nw;
        logic [31:0] np;
        logic [31:0] nc;
        int          code;
        nw = model_wait;
        np = model_pc;
        nc = model_count;
        code = ref_code();
        if (rst) begin
            nw = 1'b0;
            np = 32'd0;
            nc = 32'd0;
        end else if (!model_wait) begin
            if (code != 0) begin
                nw = 1'b1;
                np = (code == 14) ? ref_epc() : VEC;
                nc = model_count + 32'd1;
            end
        end else if (redirect_ready_i) begin
            nw = 1'b0;
        end
        @(posedge clk);
        model_wait  = nw;
        model_pc    = np;
        model_count = nc;
        #1;
    endtask

    task automatic idle_inputs();
        stall_i            = 1'b0;
        mem_valid_i        = 1'b0;
        mem_pc_i           = 32'h0;
        mem_in_delayslot_i = 1'b0;
        mem_exc_i          = 8'h0;
        mem_badaddr_i      = 32'h0;
        cp0_status_i       = 32'h0;
        cp0_cause_i        = 32'h0;
        cp0_epc_i          = 32'h0;
        wb_cp0_we_i        = 1'b0;
        wb_cp0_waddr_i     = 5'd0;
        wb_cp0_data_i      = 32'h0;
        redirect_ready_i   = 1'b1;
    endtask

    // Return to IDLE with quiet inputs before each directed scenario
    task automatic drain();
        idle_inputs();
        clock_edge();
        clock_edge();
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        idle_inputs();
        rst         = 1'b1;
        mem_valid_i = 1'b1;
        mem_exc_i   = 8'h08;
        #1;
        n_checks++;
        if (excepttype_o !== 32'd0) begin
            n_errors++;
            $display("[TB] FAIL reset_code: got %0d want 0", excepttype_o);
        end
        n_checks++;
        if (flush_o !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_flush: got %0b want 0", flush_o);
        end
        clock_edge();
        clock_edge();
        n_checks++;
        if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'd0 || exc_count_o !== 32'd0) begin
            n_errors++;
            $display("[TB] FAIL reset_regs: got valid=%0b pc=%h cnt=%0d want 0/0/0",
                     redirect_valid_o, redirect_pc_o, exc_count_o);
        end
        rst = 1'b0;
        drain();
    endtask

    task automatic test_syscall();
        mem_valid_i      = 1'b1;
        mem_pc_i         = 32'hBFC00100;
        mem_exc_i        = 8'h08;
        redirect_ready_i = 1'b0;
        #1;
        n_checks++;
        if (excepttype_o !== 32'd8 || flush_o !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL syscall_code: got code=%0d flush=%0b want 8/1", excepttype_o, flush_o);
        end
        n_checks++;
        if (current_inst_addr_o !== 32'hBFC00100 || is_in_delayslot_o !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL syscall_pass: got pc=%h ds=%0b want bfc00100/0",
                     current_inst_addr_o, is_in_delayslot_o);
        end
        clock_edge();
        mem_valid_i = 1'b0;
        mem_exc_i   = 8'h00;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (redirect_valid_o !== 1'b1 || redirect_pc_o !== VEC || flush_o !== 1'b1) begin
                n_errors++;
                $display("[TB] FAIL syscall_hold%0d: got valid=%0b pc=%h flush=%0b want 1/%h/1",
                         i, redirect_valid_o, redirect_pc_o, flush_o, VEC);
            end
            clock_edge();
        end
        redirect_ready_i = 1'b1;
        clock_edge();
        n_checks++;
        if (redirect_valid_o !== 1'b0 || exc_count_o !== 32'd1) begin
            n_errors++;
            $display("[TB] FAIL syscall_done: got valid=%0b cnt=%0d want 0/1", redirect_valid_o, exc_count_o);
        end
        drain();
    endtask

    task automatic test_priority();
        mem_valid_i      = 1'b1;
        mem_pc_i         = 32'h00400002;
        mem_exc_i        = 8'h83;
        mem_badaddr_i    = 32'h00002222;
        redirect_ready_i = 1'b0;
        #1;
        n_checks++;
        if (excepttype_o !== 32'd4 || bad_addr_o !== 32'h00400002) begin
            n_errors++;
            $display("[TB] FAIL prio_adel_if: got code=%0d bad=%h want 4/00400002", excepttype_o, bad_addr_o);
        end
        mem_exc_i     = 8'h80;
        mem_badaddr_i = 32'h00001003;
        #1;
        n_checks++;
        if (excepttype_o !== 32'd5 || bad_addr_o !== 32'h00001003) begin
            n_errors++;
            $display("[TB] FAIL prio_ades: got code=%0d bad=%h want 5/00001003", excepttype_o, bad_addr_o);
        end
        mem_exc_i = 8'h40;
        #1;
        n_checks++;
        if (excepttype_o !== 32'd4 || bad_addr_o !== 32'h00001003) begin
            n_errors++;
            $display("[TB] FAIL prio_adel_ld: got code=%0d bad=%h want 4/00001003", excepttype_o, bad_addr_o);
        end
        mem_valid_i = 1'b0;
        drain();
    endtask

    task automatic test_interrupt_fwd();
        mem_valid_i    = 1'b1;
        mem_exc_i      = 8'h02;
        cp0_status_i   = 32'h0;
        cp0_cause_i    = 32'h00000400;
        wb_cp0_we_i    = 1'b1;
        wb_cp0_waddr_i = 5'd12;
        wb_cp0_data_i  = 32'h00000401;
        #1;
        n_checks++;
        if (excepttype_o !== 32'd1) begin
            n_errors++;
            $display("[TB] FAIL int_fwd: got %0d want 1", excepttype_o);
        end
        wb_cp0_data_i = 32'h00000403;
        #1;
        n_checks++;
        if (excepttype_o !== 32'd10) begin
            n_errors++;
            $display("[TB] FAIL int_exl_masked: got %0d want 10", excepttype_o);
        end
        mem_valid_i = 1'b0;
        drain();
    endtask

    task automatic test_eret_fwd();
        mem_valid_i      = 1'b1;
        mem_exc_i        = 8'h20;
        cp0_epc_i        = 32'h00000100;
        wb_cp0_we_i      = 1'b1;
        wb_cp0_waddr_i   = 5'd14;
        wb_cp0_data_i    = 32'h00000200;
        redirect_ready_i = 1'b0;
        #1;
        n_checks++;
        if (excepttype_o !== 32'd14) begin
            n_errors++;
            $display("[TB] FAIL eret_code: got %0d want 14", excepttype_o);
        end
        clock_edge();
        n_checks++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h00000200) begin
            n_errors++;
            $display("[TB] FAIL eret_pc: got valid=%0b pc=%h want 1/00000200", redirect_valid_o, redirect_pc_o);
        end
        drain();
    endtask

    task automatic test_stall_wait();
        logic [31:0] cnt_before;
        cnt_before       = model_count;
        mem_valid_i      = 1'b1;
        mem_exc_i        = 8'h04;
        stall_i          = 1'b1;
        redirect_ready_i = 1'b0;
        #1;
        n_checks++;
        if (excepttype_o !== 32'd0 || flush_o !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL stall_hold: got code=%0d flush=%0b want 0/0", excepttype_o, flush_o);
        end
        clock_edge();
        n_checks++;
        if (redirect_valid_o !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL stall_no_take: got valid=%0b want 0", redirect_valid_o);
        end
        stall_i = 1'b0;
        #1;
        n_checks++;
        if (excepttype_o !== 32'd12 || flush_o !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL stall_release: got code=%0d flush=%0b want 12/1", excepttype_o, flush_o);
        end
        clock_edge();
        mem_exc_i = 8'h10;
        #1;
        n_checks++;
        if (excepttype_o !== 32'd0 || flush_o !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL wait_ignore: got code=%0d flush=%0b want 0/1", excepttype_o, flush_o);
        end
        clock_edge();
        clock_edge();
        n_checks++;
        if (exc_count_o !== cnt_before + 32'd1) begin
            n_errors++;
            $display("[TB] FAIL wait_count: got %0d want %0d", exc_count_o, cnt_before + 32'd1);
        end
        drain();
    endtask

    task automatic test_reset_mid_redirect();
        mem_valid_i      = 1'b1;
        mem_exc_i        = 8'h10;
        redirect_ready_i = 1'b0;
        clock_edge();
        mem_valid_i = 1'b0;
        mem_exc_i   = 8'h00;
        #1;
        n_checks++;
        if (redirect_valid_o !== 1'b1 || exc_count_o === 32'd0) begin
            n_errors++;
            $display("[TB] FAIL midrst_pre: got valid=%0b cnt=%0d want 1/nonzero", redirect_valid_o, exc_count_o);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (flush_o !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL midrst_flush: got %0b want 0", flush_o);
        end
        clock_edge();
        rst = 1'b0;
        #1;
        n_checks++;
        if (redirect_valid_o !== 1'b0 || exc_count_o !== 32'd0) begin
            n_errors++;
            $display("[TB] FAIL midrst_post: got valid=%0b cnt=%0d want 0/0", redirect_valid_o, exc_count_o);
        end
        drain();
    endtask

    task automatic test_random();
        logic [4:0] addrs [4];
        addrs[0] = 5'd12;
        addrs[1] = 5'd13;
        addrs[2] = 5'd14;
        for (int cyc = 0; cyc < 400; cyc++) begin
            addrs[3]           = 5'($urandom_range(0, 31));
            rst                = ($urandom_range(0, 99) < 2);
            stall_i            = ($urandom_range(0, 99) < 20);
            mem_valid_i        = ($urandom_range(0, 99) < 80);
            mem_pc_i           = $urandom;
            mem_in_delayslot_i = 1'($urandom_range(0, 1));
            mem_exc_i          = ($urandom_range(0, 99) < 40) ? 8'($urandom) : 8'h00;
            mem_badaddr_i      = $urandom;
            cp0_status_i       = $urandom;
            cp0_cause_i        = $urandom;
            cp0_epc_i          = $urandom;
            wb_cp0_we_i        = 1'($urandom_range(0, 1));
            wb_cp0_waddr_i     = addrs[$urandom_range(0, 3)];
            wb_cp0_data_i      = $urandom;
            redirect_ready_i   = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (excepttype_o !== 32'(ref_code()) || bad_addr_o !== ref_bad() || flush_o !== ref_flush()) begin
                n_errors++;
                $display("[TB] FAIL rand_comb@%0d: got code=%0d bad=%h flush=%0b want %0d/%h/%0b",
                         cyc, excepttype_o, bad_addr_o, flush_o, ref_code(), ref_bad(), ref_flush());
            end
            n_checks++;
            if (current_inst_addr_o !== mem_pc_i || is_in_delayslot_o !== mem_in_delayslot_i) begin
                n_errors++;
                $display("[TB] FAIL rand_pass@%0d: got pc=%h ds=%0b want %h/%0b",
                         cyc, current_inst_addr_o, is_in_delayslot_o, mem_pc_i, mem_in_delayslot_i);
            end
            clock_edge();
            n_checks++;
            if (redirect_valid_o !== model_wait || redirect_pc_o !== model_pc || exc_count_o !== model_count) begin
                n_errors++;
                $display("[TB] FAIL rand_regs@%0d: got valid=%0b pc=%h cnt=%0d want %0b/%h/%0d",
                         cyc, redirect_valid_o, redirect_pc_o, exc_count_o, model_wait, model_pc, model_count);
            end
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        model_wait  = 1'b0;
        model_pc    = 32'd0;
        model_count = 32'd0;
        rst         = 1'b1;
        idle_inputs();
        test_reset();
        test_syscall();
        test_priority();
        test_interrupt_fwd();
        test_eret_fwd();
        test_stall_wait();
        test_reset_mid_redirect();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt controller for the MEM/commit stage of the MIPS pipeline. Each cycle it gathers the exception flags of the committing instruction and the pending hardware interrupts, with CP0 write-back forwarding applied. It selects one exception by fixed priority, drives the exception-report inputs of the CP0 register file, flushes the pipeline, and holds a PC redirect to fetch until fetch accepts it.

## Interface
- `EXC_VECTOR`, default `32'hBFC00380`: general exception entry PC.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `stall_i`  in  1: pipeline held; no commit this cycle.
- `mem_valid_i`  in  1: MEM-stage slot holds a real instruction.
- `mem_pc_i`  in  32: PC of the MEM-stage instruction.
- `mem_in_delayslot_i`  in  1: instruction is in a branch delay slot.
- `mem_exc_i`  in  8: exception flags. [0] AdEL fetch, [1] RI, [2] Ov, [3] syscall, [4] break, [5] eret, [6] AdEL load, [7] AdES store.
- `mem_badaddr_i`  in  32: data address of the load/store.
- `cp0_status_i`, `cp0_cause_i`, `cp0_epc_i`  in  32 each: current CP0 register values.
- `wb_cp0_we_i`  in  1, `wb_cp0_waddr_i`  in  5, `wb_cp0_data_i`  in  32: in-flight mtc0, used for forwarding.
- `redirect_ready_i`  in  1: fetch accepts the redirect.
- `excepttype_o`  out  32: exception code to CP0. 0 = none.
- `current_inst_addr_o`  out  32, `is_in_delayslot_o`  out  1, `bad_addr_o`  out  32: to CP0.
- `flush_o`  out  1: squash IF..MEM.
- `redirect_valid_o`  out  1, `redirect_pc_o`  out  32: redirect to fetch.
- `exc_count_o`  out  32: number of exceptions taken, including eret. Wraps at 2^32.

## Operation
- **Forwarding.**
  - Effective status = `wb_cp0_data_i` when `wb_cp0_we_i` is set and `wb_cp0_waddr_i` = 12; otherwise `cp0_status_i`.
  - Effective cause = `cp0_cause_i`, with bits [9:8] taken from `wb_cp0_data_i` when a write to register 13 is in flight.
  - Effective EPC = write data when register 14 is being written; otherwise `cp0_epc_i`.
- **Interrupt pending** = `|(cause[15:8] & status[15:8]) & status[0] & ~status[1]`, using the effective values.
- **Commit cycle**: state is IDLE, `mem_valid_i` = 1 and `stall_i` = 0.
- **Exception selection** (commit cycle only; highest priority first):
  - interrupt → 1
  - AdEL fetch → 4
  - RI → 10
  - Ov → 12
  - syscall → 8
  - break → 9
  - eret → 14
  - AdEL load → 4
  - AdES store → 5
  - otherwise 0
- **Bad address**: `bad_addr_o` = `mem_pc_i` for AdEL fetch, `mem_badaddr_i` for data AdEL/AdES, 0 otherwise.
- `current_inst_addr_o` = `mem_pc_i` and `is_in_delayslot_o` = `mem_in_delayslot_i`, passed through at all times.
- **Outside a commit cycle**, `excepttype_o` is 0.
- **State machine**, states IDLE and WAIT_FETCH:
  - IDLE → WAIT_FETCH on a commit cycle with nonzero code. On that edge: latch `redirect_pc_o` (effective EPC if code 14, else `EXC_VECTOR`) and increment `exc_count_o`.
  - WAIT_FETCH → IDLE on an edge where `redirect_ready_i` = 1.
- `redirect_valid_o` = 1 in WAIT_FETCH.
- `flush_o` = 1 on the taking commit cycle and in every WAIT_FETCH cycle.

## Timing
- `excepttype_o`, `bad_addr_o` and `flush_o` are combinational, with 0-cycle latency from the MEM inputs. CP0 samples them on the same edge.
- The redirect is registered: `redirect_valid_o` rises one cycle after the commit cycle.
- Redirect handshake completes on an edge with `redirect_valid_o` & `redirect_ready_i`. Valid and PC stay stable until then.
- In WAIT_FETCH, new exceptions and interrupts are ignored and `excepttype_o` = 0. Flushed slots do not re-raise them.
- Stall with an exception flag present: nothing is taken. The exception is evaluated again when the stall drops.
- Reset values: state IDLE, `redirect_valid_o` 0, `redirect_pc_o` 0, `exc_count_o` 0. Combinational outputs are 0 while `rst` = 1.
- Reset asserted during WAIT_FETCH drops the redirect on the next edge.

## Structure
- Shared package/defines file holds:
  - exception code constants (1, 4, 5, 8, 9, 10, 12, 14);
  - CP0 register indices (12 status, 13 cause, 14 EPC);
  - `mem_exc_i` bit positions;
  - `EXC_VECTOR` default.
- One sub-module, `exc_prio`: a purely combinational priority encoder from flags plus interrupt-pending to code and bad-address select. The FSM, forwarding, counter and redirect register stay in `exc_ctrl`.

## Test plan
- **Syscall, no delay slot.** PC `0xBFC00100`, `mem_exc_i` = `0x08`, not stalled → `excepttype_o` = 8 and `flush_o` = 1 that cycle. Next cycle `redirect_valid_o` = 1 with `redirect_pc_o` = `0xBFC00380`. Hold `redirect_ready_i` = 0 for 3 cycles → valid and PC stable and `flush_o` high throughout. Ready = 1 → IDLE and `exc_count_o` = 1.
- **Priority.** `mem_exc_i` = `0x83` (AdEL fetch, RI, AdES) with PC `0x00400002` → code 4 and `bad_addr_o` = `0x00400002`. Flags `0x80` with badaddr `0x1003` → code 5 and `bad_addr_o` = `0x1003`.
- **Interrupt with forwarding.** `cp0_status_i` = 0, cause[10] = 1, WB writes status (register 12) = `0x00000401` on the same cycle with RI set → `excepttype_o` = 1. Same stimulus with status EXL = 1 → code 10.
- **Eret with EPC forwarding.** `cp0_epc_i` = `0x100`, WB writes EPC (register 14) = `0x200`, flags = `0x20` → code 14 and `redirect_pc_o` = `0x200`.
- **Stall, then WAIT_FETCH.** `stall_i` = 1 with flags `0x04` → code 0, no flush. Drop stall → code 12. During WAIT_FETCH, apply flags `0x10` → code 0 and count unchanged.
- **Reset mid-redirect.** Assert `rst` for 1 cycle in WAIT_FETCH → `redirect_valid_o` = 0 and `exc_count_o` = 0 after the edge.
